// File: rtl/pipe_stall_ctrl.sv
// Front-end pipeline controller. It owns the PC and the IF/ID register and
// responds to ID-stage hazard stalls and taken branches. It also keeps a
// saturating stall-cycle counter and a sticky watchdog flag for runaway stalls.
module pipe_stall_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b0,
    parameter int          CNT_W      = 16,
    parameter int          MAX_STALL  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallSignal,
    input  logic             brTaken,
    input  logic [31:0]      brTarget,
    input  logic [31:0]      instr_IF,
    input  logic             stat_clr,
    output logic [31:0]      pc,
    output logic [31:0]      instr_ID,
    output logic [31:0]      pcp4_ID,
    output logic             valid_ID,
    output logic             ctrl_zero_ID,
    output logic             pc_write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_err
);

    // The run counter has to hold MAX_STALL+1, where it saturates.
    localparam int             RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL + 1);

    logic [31:0]      pc_plus4;
    logic [31:0]      br_pc;
    logic             squash;
    logic [RUN_W-1:0] run_cnt;

    assign pc_plus4 = pc + 32'd4;
    assign br_pc    = {brTarget[31:2], 2'b00};

    // A taken branch squashes the wrong-path fetch unless the ISA has a delay slot.
    assign squash = brTaken & ~DELAY_SLOT;

    // A stall holds fetch, and a held or empty ID slot becomes a bubble downstream.
    assign pc_write     = ~stallSignal;
    assign ctrl_zero_ID = stallSignal | ~valid_ID;

    // PC register: stall holds it, a branch redirects it, otherwise it steps by 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
        end else if (!stallSignal) begin
            pc <= brTaken ? br_pc : pc_plus4;
        end
    end

    // IF/ID register: hold on stall, clear on squash, otherwise capture the fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ID <= 32'h0;
            pcp4_ID  <= 32'h0;
            valid_ID <= 1'b0;
        end else if (!stallSignal) begin
            if (squash) begin
                instr_ID <= 32'h0;
                pcp4_ID  <= 32'h0;
                valid_ID <= 1'b0;
            end else begin
                instr_ID <= instr_IF;
                pcp4_ID  <= pc_plus4;
                valid_ID <= 1'b1;
            end
        end
    end

    // Total stall cycles, saturating at all-ones. A clear overrides the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if (stallSignal && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Length of the current stall run, saturating one above the legal limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (!stallSignal) begin
            run_cnt <= '0;
        end else if (run_cnt != RUN_MAX) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    // Sticky watchdog: sets on a stall that extends a run already at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_err <= 1'b0;
        end else if (stat_clr) begin
            stall_err <= 1'b0;
        end else if (stallSignal && (run_cnt == RUN_LIM)) begin
            stall_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl. It runs two instances on shared stimulus:
// instance A (no delay slot, 16-bit counter, RESET_PC 0) and instance B
// (delay slot, 4-bit counter, RESET_PC 0x40). A behavioural model is
// compared against both instances on every falling edge, and literal
// expectations are checked at key points.
module tb_pipe_stall_ctrl;

    localparam int MAX_STALL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_sig = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic [31:0] instr = 32'h8C220004;
    logic        clr = 1'b0;

    logic [31:0] a_pc, a_instr, a_pcp4;
    logic        a_valid, a_cz, a_pw, a_err;
    logic [15:0] a_cnt;
    logic [31:0] b_pc, b_instr, b_pcp4;
    logic        b_valid, b_cz, b_pw, b_err;
    logic [3:0]  b_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0), .CNT_W(16), .MAX_STALL(MAX_STALL)) dut_a (
        .clk(clk), .rst_n(rst_n), .stallSignal(stall_sig), .brTaken(br), .brTarget(tgt),
        .instr_IF(instr), .stat_clr(clr), .pc(a_pc), .instr_ID(a_instr), .pcp4_ID(a_pcp4),
        .valid_ID(a_valid), .ctrl_zero_ID(a_cz), .pc_write(a_pw), .stall_cnt(a_cnt),
        .stall_err(a_err)
    );

    pipe_stall_ctrl #(.RESET_PC(32'h40), .DELAY_SLOT(1'b1), .CNT_W(4), .MAX_STALL(MAX_STALL)) dut_b (
        .clk(clk), .rst_n(rst_n), .stallSignal(stall_sig), .brTaken(br), .brTarget(tgt),
        .instr_IF(instr), .stat_clr(clr), .pc(b_pc), .instr_ID(b_instr), .pcp4_ID(b_pcp4),
        .valid_ID(b_valid), .ctrl_zero_ID(b_cz), .pc_write(b_pw), .stall_cnt(b_cnt),
        .stall_err(b_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        bit          valid;
        int          cnt;   // total stall cycles, clipped at the counter maximum
        int          run;   // length of the current stall run, unbounded
        bit          err;
    } mstate_t;

    mstate_t m [2];
    localparam logic [31:0] M_RESET_PC [2] = '{32'h0, 32'h40};
    localparam bit          M_DS       [2] = '{1'b0, 1'b1};
    localparam int          M_CMAX     [2] = '{65535, 15};

    function automatic mstate_t m_reset(input logic [31:0] rpc);
        mstate_t s;
        s.pc = rpc; s.instr = 32'h0; s.pcp4 = 32'h0; s.valid = 1'b0;
        s.cnt = 0; s.run = 0; s.err = 1'b0;
        return s;
    endfunction

    function automatic mstate_t m_step(input mstate_t s, input bit ds, input int cmax);
        mstate_t n = s;
        if (stall_sig) begin
            n.cnt = (s.cnt < cmax) ? s.cnt + 1 : cmax;
            // The run grows past the limit exactly on the stall after MAX_STALL of them.
            if (s.run == MAX_STALL) n.err = 1'b1;
            n.run = s.run + 1;
        end else begin
            n.run = 0;
            if (br && !ds) begin
                n.instr = 32'h0; n.pcp4 = 32'h0; n.valid = 1'b0;
            end else begin
                n.instr = instr; n.pcp4 = s.pc + 32'd4; n.valid = 1'b1;
            end
            n.pc = br ? (tgt & 32'hFFFF_FFFC) : s.pc + 32'd4;
        end
        if (clr) begin
            n.cnt = 0; n.err = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) m[k] = m_reset(M_RESET_PC[k]);
        end else begin
            for (int k = 0; k < 2; k++) m[k] = m_step(m[k], M_DS[k], M_CMAX[k]);
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        check("A.pc",        a_pc,          m[0].pc);
        check("A.instr_ID",  a_instr,       m[0].instr);
        check("A.pcp4_ID",   a_pcp4,        m[0].pcp4);
        check("A.valid_ID",  32'(a_valid),  32'(m[0].valid));
        check("A.ctrl_zero", 32'(a_cz),     32'(stall_sig || !m[0].valid));
        check("A.pc_write",  32'(a_pw),     32'(!stall_sig));
        check("A.stall_cnt", 32'(a_cnt),    32'(m[0].cnt));
        check("A.stall_err", 32'(a_err),    32'(m[0].err));
        check("B.pc",        b_pc,          m[1].pc);
        check("B.instr_ID",  b_instr,       m[1].instr);
        check("B.pcp4_ID",   b_pcp4,        m[1].pcp4);
        check("B.valid_ID",  32'(b_valid),  32'(m[1].valid));
        check("B.ctrl_zero", 32'(b_cz),     32'(stall_sig || !m[1].valid));
        check("B.pc_write",  32'(b_pw),     32'(!stall_sig));
        check("B.stall_cnt", 32'(b_cnt),    32'(m[1].cnt));
        check("B.stall_err", 32'(b_err),    32'(m[1].err));
    end

    // Apply one cycle of inputs, let the edge happen, return just after it.
    task automatic cycle(input bit s, input bit b, input logic [31:0] t,
                         input logic [31:0] i, input bit c);
        stall_sig = s; br = b; tgt = t; instr = i; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst.pc",        a_pc,          32'h0);
        check("rst.B.pc",      b_pc,          32'h40);
        check("rst.valid",     32'(a_valid),  32'h0);
        check("rst.ctrl_zero", 32'(a_cz),     32'h1);
        rst_n = 1'b1;

        // Reset release and sequential fetch.
        cycle(0, 0, 32'h0, 32'h8C220004, 0);
        check("seq1.pc",        a_pc,         32'h4);
        check("seq1.instr_ID",  a_instr,      32'h8C220004);
        check("seq1.pcp4_ID",   a_pcp4,       32'h4);
        check("seq1.valid_ID",  32'(a_valid), 32'h1);
        check("seq1.ctrl_zero", 32'(a_cz),    32'h0);
        cycle(0, 0, 32'h0, 32'h11, 0);
        cycle(0, 0, 32'h0, 32'h22, 0);
        cycle(0, 0, 32'h0, 32'h33, 0);

        // Load-use stall at pc 0x10.
        cycle(1, 0, 32'h0, 32'h44, 0);
        check("lu.pc",        a_pc,         32'h10);
        check("lu.instr_ID",  a_instr,      32'h33);
        check("lu.pcp4_ID",   a_pcp4,       32'h10);
        check("lu.ctrl_zero", 32'(a_cz),    32'h1);
        check("lu.pc_write",  32'(a_pw),    32'h0);
        check("lu.stall_cnt", 32'(a_cnt),   32'h1);
        cycle(0, 0, 32'h0, 32'h44, 0);
        check("lu.next_pc",   a_pc,         32'h14);

        // Taken branch, squashed (A) and delay slot (B).
        cycle(0, 1, 32'h103, 32'hAAAA0001, 0);
        check("br.pc",         a_pc,         32'h100);
        check("br.A.valid",    32'(a_valid), 32'h0);
        check("br.A.instr",    a_instr,      32'h0);
        check("br.A.ctrlzero", 32'(a_cz),    32'h1);
        check("br.B.valid",    32'(b_valid), 32'h1);
        check("br.B.instr",    b_instr,      32'hAAAA0001);
        check("br.B.pcp4",     b_pcp4,       32'h58);

        // Stall together with a branch, then the branch alone.
        cycle(1, 1, 32'h200, 32'h55, 0);
        check("sb.hold_pc",   a_pc, 32'h100);
        cycle(0, 1, 32'h200, 32'h55, 0);
        check("sb.redirect",  a_pc, 32'h200);

        // Watchdog: five consecutive stalls.
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h0, 32'h66, 0);
        check("wd.after4", 32'(a_err), 32'h0);
        cycle(1, 0, 32'h0, 32'h66, 0);
        check("wd.after5", 32'(a_err), 32'h1);
        check("wd.cnt",    32'(a_cnt), 32'd7);
        cycle(1, 0, 32'h0, 32'h66, 1);
        check("clr.cnt",   32'(a_cnt), 32'h0);
        check("clr.err",   32'(a_err), 32'h0);
        check("clr.B.cnt", 32'(b_cnt), 32'h0);
        cycle(0, 0, 32'h0, 32'h77, 0);

        // Two legal runs separated by a gap.
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h0, 32'h88, 0);
        cycle(0, 0, 32'h0, 32'h88, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h0, 32'h99, 0);
        check("gap.err", 32'(a_err), 32'h0);
        check("gap.cnt", 32'(a_cnt), 32'd8);
        cycle(0, 0, 32'h0, 32'h99, 0);

        // Counter saturation on the narrow instance.
        for (int i = 0; i < 20; i++) cycle(1, 0, 32'h0, 32'hBB, 0);
        check("sat.A.cnt", 32'(a_cnt), 32'd28);
        check("sat.B.cnt", 32'(b_cnt), 32'd15);
        check("sat.err",   32'(a_err), 32'h1);
        cycle(0, 0, 32'h0, 32'hBB, 0);

        // PC wrap at the top of the address space.
        cycle(0, 1, 32'hFFFF_FFFF, 32'hCC, 0);
        check("wrap.br_pc", a_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 32'h0, 32'hDD, 0);
        check("wrap.pc",    a_pc,         32'h0);
        check("wrap.pcp4",  a_pcp4,       32'h0);
        check("wrap.valid", 32'(a_valid), 32'h1);

        // Asynchronous reset in the middle of a stall.
        cycle(1, 0, 32'h0, 32'hEE, 0);
        cycle(1, 0, 32'h0, 32'hEE, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.pc",    a_pc,         32'h0);
        check("arst.B.pc",  b_pc,         32'h40);
        check("arst.instr", a_instr,      32'h0);
        check("arst.pcp4",  a_pcp4,       32'h0);
        check("arst.valid", 32'(a_valid), 32'h0);
        check("arst.cnt",   32'(a_cnt),   32'h0);
        check("arst.B.cnt", 32'(b_cnt),   32'h0);
        check("arst.err",   32'(a_err),   32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(0, 0, 32'h0, 32'h8C220004, 0);
        check("rel.pc",   a_pc, 32'h4);
        check("rel.B.pc", b_pc, 32'h44);
        cycle(0, 0, 32'h0, 32'h12, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
